// File: rtl/rx_serial_8n1.sv
// rx_serial_8n1: 8N1 UART receiver (1 start bit, 8 data bits LSB first, 1 stop bit).
// It synchronizes the asynchronous RX line with two flops and centre-samples each bit.
// A good byte is presented on dado_ascii together with a one-cycle pronto strobe.
// A stop bit that samples low raises a one-cycle erro_framing pulse. The FSM then
// parks in BREAK until the line returns high, so a held-low line never starts a new frame.
module rx_serial_8n1 #(
  parameter int CLKS_PER_BIT = 5208,            // 50 MHz / 9600 baud; legal minimum 4
  parameter int HALF_BIT     = CLKS_PER_BIT / 2 // start edge to start-bit centre
) (
  input  logic       clock,
  input  logic       reset,        // synchronous, active-low
  input  logic       RX,           // asynchronous serial line, idle high
  output logic [7:0] dado_ascii,
  output logic       pronto,
  output logic       erro_framing,
  output logic       ocupado,
  output logic [2:0] db_estado
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);

  // The encoding is exported on db_estado, so the values are fixed.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic [7:0]       dado_n;
  logic             pronto_n;
  logic             erro_n;
  logic             rx_m, rx_s;

  // Two-flop synchronizer; both flops reset to the idle-high line level.
  always_ff @(posedge clock) begin
    // NOTE: clocked state always uses non-blocking (<=) so every flop samples pre-edge values.
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  // State, counters, shift register and registered outputs; reset overrides everything.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      // NOTE: the shift register is explicitly cleared; a reset mid-frame must not leave stale bits.
      shreg        <= '0;
      dado_ascii   <= '0;
      pronto       <= 1'b0;
      erro_framing <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_idx      <= bit_idx_n;
      shreg        <= shreg_n;
      dado_ascii   <= dado_n;
      pronto       <= pronto_n;
      erro_framing <= erro_n;
    end
  end

  // Next-state, bit timing and byte assembly.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves a value unassigned (no latches).
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    dado_n    = dado_ascii;
    pronto_n  = 1'b0;
    erro_n    = 1'b0;

    unique case (state)
      S_IDLE: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        if (!rx_s) begin
          state_n = S_START;
        end
      end

      S_START: begin
        if (cnt == CNT_HALF_LAST) begin
          // Centre of the start bit: low confirms a frame, high was a glitch.
          cnt_n     = '0;
          bit_idx_n = '0;
          if (!rx_s) begin
            state_n = S_DATA;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt == CNT_BIT_LAST) begin
          cnt_n            = '0;
          shreg_n[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            state_n   = S_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt == CNT_BIT_LAST) begin
          // Decide at the stop-bit centre. Returning to IDLE here leaves half a bit
          // of margin before a back-to-back start edge.
          cnt_n = '0;
          if (rx_s) begin
            dado_n   = shreg;
            pronto_n = 1'b1;
            state_n  = S_IDLE;
          end else begin
            erro_n  = 1'b1;
            state_n = S_BREAK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_BREAK: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        if (rx_s) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        state_n   = S_IDLE;
      end
    endcase
  end

  assign ocupado   = (state != S_IDLE);
  assign db_estado = state;

endmodule

// File: tb/tb_rx_serial_8n1.sv
// tb_rx_serial_8n1: directed bench for the 8N1 receiver at 8 clocks per bit.
// It drives RX on falling clock edges and samples DUT outputs on falling edges.
// A table of frames covers the main decode path. Hand-written sequences cover reset,
// glitch, break and mid-frame reset.
module tb_rx_serial_8n1;

  localparam int CPB    = 8;
  localparam int HALF   = CPB / 2;
  localparam int PERIOD = 10;
  localparam int LAT    = 2 + HALF + 9 * CPB;   // RX falling edge to pronto, in cycles

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       RX    = 1'b1;
  logic [7:0] dado_ascii;
  logic       pronto;
  logic       erro_framing;
  logic       ocupado;
  logic [2:0] db_estado;

  always #(PERIOD / 2) clock = ~clock;

  rx_serial_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clock        (clock),
    .reset        (reset),
    .RX           (RX),
    .dado_ascii   (dado_ascii),
    .pronto       (pronto),
    .erro_framing (erro_framing),
    .ocupado      (ocupado),
    .db_estado    (db_estado)
  );

  int  n_checks   = 0;
  int  n_fail     = 0;
  int  pronto_cnt = 0;
  int  erro_cnt   = 0;
  int  busy_cnt   = 0;
  bit  prev_pulse = 1'b0;
  time t_start    = 0;
  time t_pronto   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: counts strobes and busy cycles, and checks the strobes stay exclusive and isolated.
  always @(negedge clock) begin
    if (ocupado === 1'b1) busy_cnt++;
    if (pronto === 1'b1) begin
      pronto_cnt++;
      t_pronto = $time;
    end
    if (erro_framing === 1'b1) erro_cnt++;
    if (pronto === 1'b1 || erro_framing === 1'b1) begin
      check("pulse_exclusive", int'(pronto & erro_framing), 0);
      check("pulse_not_consecutive", int'(prev_pulse), 0);
    end
    prev_pulse = (pronto === 1'b1) || (erro_framing === 1'b1);
  end

  // Hold the line high for n bit-clocks.
  task automatic idle(input int n);
    @(negedge clock);
    RX = 1'b1;
    repeat (n - 1) @(negedge clock);
  endtask

  // One full frame, each bit CPB clocks long; the line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clock);
    RX      = 1'b0;
    t_start = $time;
    repeat (CPB - 1) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      RX = b[i];
      repeat (CPB - 1) @(negedge clock);
    end
    @(negedge clock);
    RX = stop;
    repeat (CPB - 1) @(negedge clock);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;       // idle-high clocks after the frame; 0 = back-to-back
    logic [7:0] exp_dado;
    int         exp_pronto;
    int         exp_erro;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int p0, e0, b0, lat;

    vecs[0] = '{8'h35, 1'b1, 16, 8'h35, 1, 0};
    vecs[1] = '{8'h30, 1'b1,  0, 8'h30, 1, 0};
    vecs[2] = '{8'h39, 1'b1,  0, 8'h39, 1, 0};
    vecs[3] = '{8'h41, 1'b1, 16, 8'h41, 1, 0};
    vecs[4] = '{8'hA5, 1'b1, 16, 8'hA5, 1, 0};
    vecs[5] = '{8'hC3, 1'b0, 16, 8'hA5, 0, 1};   // bad stop: byte not taken
    vecs[6] = '{8'h00, 1'b1, 16, 8'h00, 1, 0};
    vecs[7] = '{8'hFF, 1'b1, 16, 8'hFF, 1, 0};

    // Reset, then idle.
    reset = 1'b0;
    RX    = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_dado", int'(dado_ascii), 0);
    check("rst_pronto", int'(pronto), 0);
    check("rst_erro", int'(erro_framing), 0);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_estado", int'(db_estado), 0);
    reset = 1'b1;
    repeat (50) @(negedge clock);
    check("idle_dado", int'(dado_ascii), 0);
    check("idle_estado", int'(db_estado), 0);
    check("idle_busy_cycles", busy_cnt, 0);
    check("idle_pronto_count", pronto_cnt, 0);
    check("idle_erro_count", erro_cnt, 0);

    // Glitch: RX low for 2 cycles.
    b0 = busy_cnt;
    p0 = pronto_cnt;
    @(negedge clock);
    RX = 1'b0;
    @(negedge clock);
    @(negedge clock);
    RX = 1'b1;
    repeat (20) @(negedge clock);
    check("glitch_entered_start", int'((busy_cnt - b0) >= 1), 1);
    check("glitch_busy_bound", int'((busy_cnt - b0) <= HALF + 2), 1);
    check("glitch_no_pronto", pronto_cnt - p0, 0);
    check("glitch_estado", int'(db_estado), 0);
    check("glitch_dado", int'(dado_ascii), 0);

    // Framing error followed by a held-low line.
    p0 = pronto_cnt;
    e0 = erro_cnt;
    send_frame(8'h55, 1'b0);
    repeat (20) @(negedge clock);
    check("break_estado", int'(db_estado), 4);
    check("break_ocupado", int'(ocupado), 1);
    check("break_erro_count", erro_cnt - e0, 1);
    check("break_no_pronto", pronto_cnt - p0, 0);
    check("break_dado_kept", int'(dado_ascii), 0);
    repeat (20) @(negedge clock);
    check("break_still_held", int'(db_estado), 4);
    check("break_no_new_erro", erro_cnt - e0, 1);
    idle(16);
    check("break_exit_estado", int'(db_estado), 0);
    check("break_exit_ocupado", int'(ocupado), 0);

    // Valid byte after the break, with latency measured from the start edge.
    p0 = pronto_cnt;
    e0 = erro_cnt;
    send_frame(8'h37, 1'b1);
    idle(16);
    // Start is driven on a falling edge and pronto is seen on a falling edge; the
    // two half-cycle offsets add up to one clock on top of the edge-to-edge latency.
    lat = int'((t_pronto - t_start) / PERIOD) - 1;
    check("after_break_pronto", pronto_cnt - p0, 1);
    check("after_break_erro", erro_cnt - e0, 0);
    check("after_break_dado", int'(dado_ascii), 8'h37);
    check("frame_latency", lat, LAT);

    // Table of frames, including back-to-back ones.
    for (int i = 0; i < 8; i++) begin
      p0 = pronto_cnt;
      e0 = erro_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      if (vecs[i].gap > 0) idle(vecs[i].gap);
      #1;
      check($sformatf("vec%0d_dado", i), int'(dado_ascii), int'(vecs[i].exp_dado));
      check($sformatf("vec%0d_pronto", i), pronto_cnt - p0, vecs[i].exp_pronto);
      check($sformatf("vec%0d_erro", i), erro_cnt - e0, vecs[i].exp_erro);
      if (vecs[i].gap > 0) check($sformatf("vec%0d_ocupado", i), int'(ocupado), 0);
    end

    // Reset during data bit 4 of 0x36, then a clean 0x32.
    p0 = pronto_cnt;
    e0 = erro_cnt;
    @(negedge clock);
    RX = 1'b0;
    repeat (CPB - 1) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      RX = 8'h36 >> i;
      repeat ((i == 4) ? 3 : CPB - 1) @(negedge clock);
    end
    check("midrst_busy_before", int'(db_estado), 2);
    @(negedge clock);
    reset = 1'b0;
    RX    = 1'b1;
    repeat (2) @(negedge clock);
    check("midrst_ocupado", int'(ocupado), 0);
    check("midrst_estado", int'(db_estado), 0);
    check("midrst_dado_cleared", int'(dado_ascii), 0);
    reset = 1'b1;
    repeat (20 * CPB) @(negedge clock);
    check("midrst_no_pronto", pronto_cnt - p0, 0);
    check("midrst_no_erro", erro_cnt - e0, 0);
    send_frame(8'h32, 1'b1);
    idle(16);
    check("midrst_next_dado", int'(dado_ascii), 8'h32);
    check("midrst_next_pronto", pronto_cnt - p0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/rx_serial_8n1.md
Name: rx_serial_8n1

Overview:
- UART receiver, 8N1 framing: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.
- Sits directly upstream of the ASCII-digit decoder.
- Captures one byte from the asynchronous serial line and presents it on `dado_ascii` with a one-cycle `pronto` strobe.
- Flags framing errors.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal minimum 4.
- HALF_BIT, CLKS_PER_BIT/2, cycles from start-bit falling edge to start-bit mid-sample.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low; sampled on rising edge of clock.
- RX  input  1  asynchronous serial line, idle high.
- dado_ascii  output  8  last correctly framed byte; held until next good byte.
- pronto  output  1  one-cycle pulse when dado_ascii updates.
- erro_framing  output  1  one-cycle pulse when the stop bit samples 0.
- ocupado  output  1  high whenever FSM is not in IDLE.
- db_estado  output  3  FSM state encoding, for debug.

Behaviour:
Reset:
- reset=0 at a rising edge puts the FSM in IDLE and clears all counters and the shift register.
- Reset values: dado_ascii=0x00, pronto=0, erro_framing=0, ocupado=0, db_estado=0.
- Synchronizer flops reset to 1 (line idle).
- Reset wins over every other event, including mid-frame; the partial byte is discarded with no strobe.

Input synchronizer:
- RX passes through a 2-flop synchronizer; rx_s is the second flop.
- All decisions use rx_s, so line-to-decision latency is 2 cycles.

FSM states (db_estado): IDLE=0, START=1, DATA=2, STOP=3, BREAK=4.

IDLE:
- On rx_s=0, go to START with cnt=0.

START:
- cnt increments each cycle.
- At cnt=HALF_BIT-1, sample rx_s.
- If rx_s=0 (valid start), go to DATA with cnt=0 and bit_idx=0.
- If rx_s=1 (glitch), go to IDLE; no outputs change.

DATA:
- cnt increments.
- At cnt=CLKS_PER_BIT-1, sample rx_s into shreg[bit_idx] (LSB first), then clear cnt.
- After the sample with bit_idx=7, go to STOP; otherwise bit_idx increments.

STOP:
- At cnt=CLKS_PER_BIT-1, sample rx_s.
- If rx_s=1: dado_ascii<=shreg, pronto=1 for exactly that one registered cycle, go to IDLE.
- If rx_s=0: erro_framing=1 for one cycle, dado_ascii unchanged, go to BREAK.

BREAK:
- Stay until rx_s=1, then go to IDLE.
- A held-low line (break) must never be parsed as new frames.

Outputs and timing:
- ocupado=1 in START, DATA, STOP, BREAK.
- pronto and erro_framing are mutually exclusive and never high two consecutive cycles.
- Back-to-back frames: a start bit beginning right after the stop mid-sample is accepted. The FSM returns to IDLE at the stop-bit centre, leaving half a bit of margin.
- Frame latency: pronto rises 2 + HALF_BIT + 9*CLKS_PER_BIT cycles (±1) after the RX falling edge.
- cnt width is clog2(CLKS_PER_BIT); cnt and bit_idx never wrap in normal flow; both are explicitly cleared at every state change.

Test Plan (CLKS_PER_BIT=8):
- Reset then idle: hold reset=0 for 3 cycles with RX=1, then release for 50 cycles -> dado_ascii=0x00; pronto, erro_framing, ocupado all stay 0; db_estado=0.
- Single byte: send 0x35 ('5') at 8 clocks/bit -> exactly one pronto pulse about 78 cycles after the start edge; dado_ascii=0x35; erro_framing never 1; ocupado returns to 0.
- Back-to-back: send 0x30, 0x39, 0x41 with no idle gap -> three pronto pulses; dado_ascii sequence 0x30, 0x39, 0x41; no erro_framing.
- Glitch rejection: RX low for 2 cycles, then high -> FSM goes IDLE→START→IDLE; no pronto; ocupado high for at most HALF_BIT+2 cycles.
- Framing error: send 0x55 with stop bit=0, line held low 40 cycles, then high, then a valid 0x37 -> one erro_framing pulse; dado_ascii stays at its previous value (0x00); FSM sits in BREAK (db_estado=4) while low; then pronto with dado_ascii=0x37.
- Reset mid-frame: assert reset=0 during data bit 4 of 0x36, release, then send 0x32 -> no pronto for 0x36; dado_ascii=0x32 after the second frame.
